// File: rtl/loader_pkg.sv
// Shared constants for the boot-time memory loader: command codes and FSM encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package loader_pkg;

  // Command bytes recognised at the start of each stream section
  localparam logic [7:0] CMD_INS = 8'h01;
  localparam logic [7:0] CMD_MEM = 8'h02;
  localparam logic [7:0] CMD_END = 8'h03;

  // Loader FSM state encoding
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_COUNT = 3'd1;
  localparam state_t ST_DATA  = 3'd2;
  localparam state_t ST_WRITE = 3'd3;
  localparam state_t ST_DONE  = 3'd4;
  localparam state_t ST_ERROR = 3'd5;

endpackage

// File: rtl/word_packer.sv
// Assembles a little-endian byte stream into WIDTH-bit words, one lane per accepted byte.
// Latency: word_o/last_o are combinational and already include the byte being offered.
// Backpressure: none of its own; the parent qualifies byte_vld_i with its accept condition.
module word_packer
  import loader_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             byte_vld_i,
  input  logic [7:0]       byte_dat_i,
  output logic [WIDTH-1:0] word_o,
  output logic             last_o
);

  localparam int NB = WIDTH / 8;
  localparam int LW = (NB > 1) ? $clog2(NB) : 1;

  logic [LW-1:0]    lane_q, lane_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [WIDTH-1:0] word_nxt;

  assign last_o = (lane_q == LW'(NB - 1));
  assign word_o = word_nxt;

  // Merge the offered byte into its lane so the parent sees the finished word in the same cycle
  always_comb begin
    word_nxt = word_q;
    word_nxt[lane_q*8 +: 8] = byte_dat_i;
    word_d = word_q;
    lane_d = lane_q;
    if (byte_vld_i) begin
      word_d = word_nxt;
      lane_d = last_o ? '0 : lane_q + 1'b1;
    end
  end

  // Lane counter and partial word; reset drops any half-built word
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q <= '0;
      word_q <= '0;
    end else begin
      lane_q <= lane_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/mem_loader.sv
// Parses a command/count/data byte stream and writes words into instruction or data memory.
// Latency: write strobe fires the cycle after the final byte of a word is accepted.
// Backpressure: rx_ready drops for the single WRITE cycle and permanently in DONE/ERROR.
module mem_loader
  import loader_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              sel,
  output logic [WIDTH-1:0]  wr_data,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              ins_we,
  output logic              mem_we,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  // One extra bit so a count byte of 0 can hold the full 2^ADDR_W word count
  localparam int RW = ADDR_W + 1;
  localparam logic [RW-1:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

  state_t            state_q, state_d;
  logic              sel_q, sel_d;
  logic [RW-1:0]     rem_q, rem_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0]  wr_data_q, wr_data_d;

  logic              accept;
  logic              pk_last;
  logic [WIDTH-1:0]  pk_word;

  assign rx_ready = ~rst & ((state_q == ST_IDLE) | (state_q == ST_COUNT) | (state_q == ST_DATA));
  assign accept   = rx_valid & rx_ready;

  word_packer #(.WIDTH(WIDTH)) u_packer (
    .clk        (clk),
    .rst        (rst),
    .byte_vld_i (accept & (state_q == ST_DATA)),
    .byte_dat_i (rx_data),
    .word_o     (pk_word),
    .last_o     (pk_last)
  );

  // Strobes and status decode straight from state; rst gates them so nothing leaks during reset
  assign sel       = sel_q;
  assign wr_data   = wr_data_q;
  assign wr_addr   = wr_addr_q;
  assign ins_we    = ~rst & (state_q == ST_WRITE) & ~sel_q;
  assign mem_we    = ~rst & (state_q == ST_WRITE) &  sel_q;
  assign cpu_hold  = rst | (state_q != ST_DONE);
  assign load_done = ~rst & (state_q == ST_DONE);
  assign load_err  = ~rst & (state_q == ST_ERROR);

  // Stream parser: command, count, data bytes, then a one-cycle write per word
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    rem_d     = rem_q;
    addr_d    = addr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (rx_data == CMD_INS) begin
            sel_d   = 1'b0;
            state_d = ST_COUNT;
          end else if (rx_data == CMD_MEM) begin
            sel_d   = 1'b1;
            state_d = ST_COUNT;
          end else if (rx_data == CMD_END) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ERROR;
          end
        end
      end
      ST_COUNT: begin
        if (accept) begin
          rem_d     = (rx_data == 8'd0) ? FULL_CNT : RW'(rx_data);
          addr_d    = '0;
          wr_addr_d = '0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (accept && pk_last) begin
          wr_data_d = pk_word;
          wr_addr_d = addr_q;
          state_d   = ST_WRITE;
        end
      end
      ST_WRITE: begin
        addr_d  = addr_q + 1'b1;
        rem_d   = rem_q - 1'b1;
        state_d = (rem_q == RW'(1)) ? ST_IDLE : ST_DATA;
      end
      ST_DONE:  state_d = ST_DONE;
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sel_q     <= 1'b0;
      rem_q     <= '0;
      addr_q    <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      rem_q     <= rem_d;
      addr_q    <= addr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader with a scoreboard of expected memory writes.
// Latency: checks that each strobe lands the cycle after a word's last byte.
// Backpressure: drives rx_valid and waits (bounded) on rx_ready.
module tb_mem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        sel;
  logic [31:0] wr_data;
  logic [7:0]  wr_addr;
  logic        ins_we;
  logic        mem_we;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;

  typedef struct packed {
    logic        sel;
    logic [7:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic last_strobe = 1'b0;

  mem_loader #(.WIDTH(32), .ADDR_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .sel       (sel),
    .wr_data   (wr_data),
    .wr_addr   (wr_addr),
    .ins_we    (ins_we),
    .mem_we    (mem_we),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, sample 1 ns after the edge, and score any write strobe seen
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    last_strobe = ins_we | mem_we;
    if (last_strobe !== 1'b0) begin
      chk("we_exclusive", 64'(ins_we & mem_we), 64'd0);
      if (sb.size() == 0) begin
        chk("unexpected_strobe", 64'(last_strobe), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("write", 64'({mem_we, ins_we, sel, wr_addr, wr_data}),
            64'({e.sel, ~e.sel, e.sel, e.addr, e.data}));
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int w = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    if (w == 20) chk("rdy_timeout", 64'(rx_ready), 64'd1);
    else tick();
    rx_valid = 1'b0;
  endtask

  // Queue the expected write, send the word LSB first, and confirm the strobe came next cycle
  task automatic send_word(input logic s, input logic [7:0] a, input logic [31:0] w, input int gap);
    logic [31:0] v;
    sb.push_back('{sel: s, addr: a, data: w});
    v = w;
    for (int i = 0; i < 4; i++) begin
      repeat (gap) tick();
      send_byte(v[i*8 +: 8]);
    end
    chk("strobe_latency", 64'(last_strobe), 64'd1);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  // Hold a byte on the bus for n cycles where the loader must refuse it
  task automatic drive_ignored(input logic [7:0] b, input int n);
    rx_data  = b;
    rx_valid = 1'b1;
    repeat (n) tick();
    rx_valid = 1'b0;
  endtask

  logic [7:0] bi;

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;

    // Reset values
    repeat (2) tick();
    chk("rst_ready", 64'(rx_ready), 64'd0);
    chk("rst_outs", 64'({sel, wr_data, wr_addr, ins_we, mem_we}), 64'd0);
    chk("rst_status", 64'({cpu_hold, load_done, load_err}), 64'b100);
    rst = 1'b0;
    tick();
    chk("idle_ready", 64'(rx_ready), 64'd1);

    // Two instruction words, then END
    send_byte(8'h01); send_byte(8'h02);
    send_word(1'b0, 8'd0, 32'h44332211, 0);
    send_word(1'b0, 8'd1, 32'hDDCCBBAA, 0);
    send_byte(8'h03);
    chk("ins_sb_empty", 64'(sb.size()), 64'd0);
    chk("ins_done", 64'({load_done, cpu_hold, load_err, rx_ready}), 64'b1000);
    chk("ins_hold_wr", 64'({sel, wr_addr, wr_data}), 64'({1'b0, 8'd1, 32'hDDCCBBAA}));
    drive_ignored(8'h01, 6);
    chk("done_sticky", 64'({load_done, cpu_hold}), 64'b10);

    // Reset after DONE restores hold
    rst = 1'b1;
    tick();
    chk("rst_after_done", 64'({cpu_hold, load_done, rx_ready}), 64'b100);
    rst = 1'b0;
    tick();

    // Single data-memory word
    send_byte(8'h02); send_byte(8'h01);
    send_word(1'b1, 8'd0, 32'h12345678, 0);
    send_byte(8'h03);
    chk("mem_sb_empty", 64'(sb.size()), 64'd0);
    chk("mem_sel_done", 64'({sel, load_done}), 64'b11);

    // Illegal command
    do_reset();
    send_byte(8'h07);
    chk("err_status", 64'({load_err, rx_ready, cpu_hold, load_done}), 64'b1010);
    drive_ignored(8'h01, 4);
    drive_ignored(8'h03, 4);
    chk("err_sticky", 64'({load_err, load_done}), 64'b10);

    // Same instruction stream with 3-cycle idle gaps between bytes
    do_reset();
    send_byte(8'h01); send_byte(8'h02);
    send_word(1'b0, 8'd0, 32'h44332211, 3);
    send_word(1'b0, 8'd1, 32'hDDCCBBAA, 3);
    send_byte(8'h03);
    chk("gap_sb_empty", 64'(sb.size()), 64'd0);
    chk("gap_done", 64'(load_done), 64'd1);

    // Reset in the middle of a word discards it
    do_reset();
    send_byte(8'h01); send_byte(8'h02);
    send_byte(8'h11); send_byte(8'h22);
    rst = 1'b1;
    tick();
    chk("midrst_no_we", 64'({ins_we, mem_we}), 64'd0);
    rst = 1'b0;
    tick();
    chk("midrst_idle", 64'({rx_ready, load_err}), 64'b10);
    send_byte(8'h01); send_byte(8'h01);
    send_word(1'b0, 8'd0, 32'hD4C3B2A1, 0);
    send_byte(8'h03);
    chk("midrst_sb_empty", 64'(sb.size()), 64'd0);

    // Count of zero: full 256-word data section with address wrap
    do_reset();
    send_byte(8'h02); send_byte(8'h00);
    for (int i = 0; i < 256; i++) begin
      bi = i[7:0];
      send_word(1'b1, bi, {bi, ~bi, bi ^ 8'h5A, bi + 8'd1}, 0);
    end
    tick();
    chk("full_sb_empty", 64'(sb.size()), 64'd0);
    chk("full_idle", 64'({rx_ready, load_err, load_done, wr_addr}), 64'({3'b100, 8'd255}));
    send_byte(8'h03);
    chk("full_done", 64'({load_done, cpu_hold}), 64'b10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
